// File: rtl/dw_dx_accum_if.sv
// dw_dx_accum_if -- handshake bundle between a duplex multiplier stream
// and the dw_dx_accum frame accumulator.
//
// Parameters must match the accumulator instance (width, guard).
//   product   : 2*width           multiplier product, simplex or {hi, lo}
//   tc, dplx  : 1                 frame mode, sampled on the first beat
//   in_valid  : 1 / in_ready : 1  product beat handshake
//   clr       : 1                 synchronous frame abort
//   acc_out   : 2*width+2*guard   frame result
//   ovf       : 2                 per-lane overflow {hi, lo}
//   out_valid : 1 / out_ready : 1 result handshake
// master = product source / result sink, slave = accumulator.
interface dw_dx_accum_if #(
  parameter int width = 16,
  parameter int guard = 4
);
  logic [2*width-1:0]         product;
  logic                       tc;
  logic                       dplx;
  logic                       in_valid;
  logic                       in_ready;
  logic                       clr;
  logic [2*width+2*guard-1:0] acc_out;
  logic [1:0]                 ovf;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output product, tc, dplx, in_valid, clr, out_ready,
    input  in_ready, acc_out, ovf, out_valid
  );

  modport slave (
    input  product, tc, dplx, in_valid, clr, out_ready,
    output in_ready, acc_out, ovf, out_valid
  );
endinterface

// File: rtl/dw_dx_accum.sv
// dw_dx_accum -- frame accumulator for a simplex/duplex multiplier.
//
// Sums acc_len product beats per frame. Simplex frames use one wide lane;
// duplex frames split the product into independent lo/hi lanes with no
// carry between them. Frame mode (tc, dplx) is captured on the first beat.
// The result is held with out_valid until out_ready; in_ready is low while
// a result is pending.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   io     : dw_dx_accum_if.slave (product, tc, dplx, in_valid/in_ready,
//            clr, acc_out, ovf, out_valid/out_ready)
//
// Build option: define DW_DX_ACCUM_SAT_EN to clamp an overflowing lane to
// its max/min and hold it there for the rest of the frame; otherwise lanes
// wrap. ovf is sticky per frame in both builds.
module dw_dx_accum #(
  parameter int width    = 16,
  parameter int p1_width = 8,
  parameter int acc_len  = 4,
  parameter int guard    = 4
) (
  input logic          clk,
  input logic          rst_n,
  dw_dx_accum_if.slave io
);

  localparam int p2_width = width - p1_width;
  localparam int AW = 2*width + 2*guard;   // acc_out width
  localparam int SW = 2*width + guard;     // simplex lane significant width
  localparam int LW = 2*p1_width + guard;  // duplex lo lane
  localparam int HW = 2*p2_width + guard;  // duplex hi lane
  localparam int WW = AW + 2;              // headroom so lane sums never wrap
  localparam int CW = $clog2(acc_len);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [1:0]     ovf_q, ovf_d;
  logic           tc_q, tc_d;
  logic           dplx_q, dplx_d;
  logic           rdy_q;

  logic           accept, first, last, tc_f, dx_f;
  logic [AW-1:0]  base;
  logic [1:0]     ovf_b;
  logic [WW:0]    rs, rl, rh;
  logic [WW-1:0]  sx;
  logic           unused_bits;

  // Sign- (is_tc) or zero-extend the low n bits of v to the full work width.
  function automatic logic signed [WW-1:0] ext(input logic [WW-1:0] v,
                                               input int n,
                                               input logic is_tc);
    int sh;
    logic signed [WW-1:0] t;
    sh = WW - n;
    t  = $signed(v << sh);
    return is_tc ? (t >>> sh) : $signed((v << sh) >> sh);
  endfunction

  // One lane add with range check for an n-bit lane. Returns {ovf, value};
  // the caller keeps the low n bits of value (which is the wrapped result
  // when saturation is not built in).
  function automatic logic [WW:0] lane_step(input logic signed [WW-1:0] a,
                                            input logic signed [WW-1:0] b,
                                            input int n,
                                            input logic is_tc,
                                            input logic ovf_in);
    logic signed [WW-1:0] one, mx, mn, s, r;
    logic o;
    one = {{(WW-1){1'b0}}, 1'b1};
    mx  = is_tc ? (one <<< (n-1)) - one : (one <<< n) - one;
    mn  = is_tc ? -(one <<< (n-1)) : '0;
    s   = a + b;
    o   = (s > mx) || (s < mn);
    r   = s;
`ifdef DW_DX_ACCUM_SAT_EN
    // A lane that already overflowed keeps its clamped value.
    if (ovf_in)      r = a;
    else if (s > mx) r = mx;
    else if (s < mn) r = mn;
`endif
    return {ovf_in | o, r};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    tc_d    = tc_q;
    dplx_d  = dplx_q;

    first  = (state_q == IDLE);
    accept = io.in_valid & rdy_q;
    last   = (cnt_q == CW'(acc_len - 1));
    // The first beat of a frame loads rather than adds, and defines the mode.
    tc_f   = first ? io.tc   : tc_q;
    dx_f   = first ? io.dplx : dplx_q;
    base   = first ? '0      : acc_q;
    ovf_b  = first ? 2'b00   : ovf_q;

    rs = lane_step(ext(WW'(base[SW-1:0]), SW, tc_f),
                   ext(WW'(io.product), 2*width, tc_f),
                   SW, tc_f, ovf_b[0]);
    rl = lane_step(ext(WW'(base[LW-1:0]), LW, tc_f),
                   ext(WW'(io.product[2*p1_width-1:0]), 2*p1_width, tc_f),
                   LW, tc_f, ovf_b[0]);
    rh = lane_step(ext(WW'(base[AW-1:LW]), HW, tc_f),
                   ext(WW'(io.product[2*width-1:2*p1_width]), 2*p2_width, tc_f),
                   HW, tc_f, ovf_b[1]);

    case (state_q)
      IDLE, ACCUM: begin
        if (io.clr) begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = '0;
        end else if (accept) begin
          tc_d   = tc_f;
          dplx_d = dx_f;
          if (dx_f) begin
            acc_d = {rh[HW-1:0], rl[LW-1:0]};
            ovf_d = {rh[WW], rl[WW]};
          end else begin
            // Simplex keeps SW significant bits; the top guard bits of
            // acc_out are regenerated as sign/zero extension on output.
            acc_d = AW'(rs[SW-1:0]);
            ovf_d = {1'b0, rs[WW]};
          end
          cnt_d   = last ? '0 : cnt_q + 1'b1;
          state_d = last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= '0;
      tc_q    <= 1'b0;
      dplx_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      tc_q    <= tc_d;
      dplx_q  <= dplx_d;
      // Registered so in_ready never depends combinationally on inputs.
      rdy_q   <= (state_d != HOLD);
    end
  end

  assign sx           = ext(WW'(acc_q[SW-1:0]), SW, tc_q);
  assign io.acc_out   = dplx_q ? acc_q : sx[AW-1:0];
  assign io.ovf       = ovf_q;
  assign io.out_valid = (state_q == HOLD);
  assign io.in_ready  = rdy_q;

  assign unused_bits = ^{rs[WW-1:SW], rl[WW-1:LW], rh[WW-1:HW], sx[WW-1:AW]};

endmodule

// File: tb/tb_dw_dx_accum.sv
module tb_dw_dx_accum;
  localparam int W  = 16;
  localparam int P1 = 8;
  localparam int N  = 4;

`ifdef DW_DX_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [63:0] acc;
    logic [1:0]  ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] pa [4];

  dw_dx_accum_if #(.width(W), .guard(4)) io0 ();
  dw_dx_accum_if #(.width(W), .guard(1)) io1 ();

  dw_dx_accum #(.width(W), .p1_width(P1), .acc_len(N), .guard(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .io(io0.slave));
  dw_dx_accum #(.width(W), .p1_width(P1), .acc_len(N), .guard(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .io(io1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // One lane of a frame in plain integer arithmetic: the true running sum,
  // checked against the n-bit lane range after every beat.
  function automatic void lane_model(input logic [31:0] p [4], input int lsb,
                                     input int w, input int n, input bit tc,
                                     output longint acc, output bit o);
    longint v, hi, lo, m;
    m  = (64'sd1 <<< n) - 1;
    hi = tc ? (64'sd1 <<< (n-1)) - 1 : m;
    lo = tc ? -(64'sd1 <<< (n-1)) : 64'sd0;
    acc = 0;
    o   = 1'b0;
    for (int i = 0; i < N; i++) begin
      v = $signed({32'b0, p[i]});
      v = (v >>> lsb) & ((64'sd1 <<< w) - 1);
      if (tc && (((v >>> (w-1)) & 1) == 1)) v = v - (64'sd1 <<< w);
      if (!(SAT && o)) begin
        acc = acc + v;
        if (acc > hi || acc < lo) begin
          o = 1'b1;
          if (SAT) acc = (acc > hi) ? hi : lo;
          else begin
            acc = acc & m;
            if (tc && acc > hi) acc = acc - (64'sd1 <<< n);
          end
        end
      end
    end
  endfunction

  function automatic exp_t model(input logic [31:0] p [4], input bit tc,
                                 input bit dx, input int g);
    exp_t   e;
    longint a, b, m;
    bit     oa, ob;
    if (!dx) begin
      lane_model(p, 0, 2*W, 2*W + g, tc, a, oa);
      m = (64'sd1 <<< (2*W + 2*g)) - 1;
      e.acc = 64'(a & m);
      e.ovf = {1'b0, oa};
    end else begin
      lane_model(p, 0, 2*P1, 2*P1 + g, tc, a, oa);
      lane_model(p, 2*P1, 2*(W-P1), 2*(W-P1) + g, tc, b, ob);
      m = (64'sd1 <<< (2*P1 + g)) - 1;
      e.acc = 64'(((b & ((64'sd1 <<< (2*(W-P1) + g)) - 1)) <<< (2*P1 + g)) | (a & m));
      e.ovf = {ob, oa};
    end
    return e;
  endfunction

  // Scoreboard: every cycle a result is presented it must match the oldest
  // expected frame; it retires when out_ready completes the handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (io0.out_valid) begin
        if (q0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL scb0_valid: got out_valid=1 required 0 (no frame pending)");
        end else begin
          chk("scb0_acc", 64'(io0.acc_out), q0[0].acc);
          chk("scb0_ovf", 64'(io0.ovf), 64'(q0[0].ovf));
          if (io0.out_ready) q0.delete(0);
        end
      end
      if (io1.out_valid) begin
        if (q1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL scb1_valid: got out_valid=1 required 0 (no frame pending)");
        end else begin
          chk("scb1_acc", 64'(io1.acc_out), q1[0].acc);
          chk("scb1_ovf", 64'(io1.ovf), 64'(q1[0].ovf));
          if (io1.out_ready) q1.delete(0);
        end
      end
    end
  end

  task automatic beat(input int idx, input logic [31:0] p, input bit tc,
                      input bit dx, input bit cl);
    if (idx == 0) begin
      chk("in_ready0", 64'(io0.in_ready), 64'd1);
      io0.product = p; io0.tc = tc; io0.dplx = dx; io0.clr = cl; io0.in_valid = 1'b1;
    end else begin
      chk("in_ready1", 64'(io1.in_ready), 64'd1);
      io1.product = p; io1.tc = tc; io1.dplx = dx; io1.clr = cl; io1.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    io0.in_valid = 1'b0; io0.clr = 1'b0;
    io1.in_valid = 1'b0; io1.clr = 1'b0;
  endtask

  // Later beats drive the opposite mode bits; the frame must ignore them.
  task automatic send_frame(input int idx, input logic [31:0] p [4],
                            input bit tc, input bit dx);
    exp_t e;
    e = model(p, tc, dx, (idx == 0) ? 4 : 1);
    if (idx == 0) q0.push_back(e); else q1.push_back(e);
    for (int i = 0; i < N; i++) begin
      chk("out_valid_early", 64'((idx == 0) ? io0.out_valid : io1.out_valid), 64'd0);
      beat(idx, p[i], (i == 0) ? tc : !tc, (i == 0) ? dx : !dx, 1'b0);
    end
    chk("out_valid_after_last", 64'((idx == 0) ? io0.out_valid : io1.out_valid), 64'd1);
  endtask

  task automatic handshake(input int idx);
    if (idx == 0) io0.out_ready = 1'b1; else io1.out_ready = 1'b1;
    @(posedge clk); #1;
    io0.out_ready = 1'b0; io1.out_ready = 1'b0;
    chk("hs_out_valid", 64'((idx == 0) ? io0.out_valid : io1.out_valid), 64'd0);
    chk("hs_in_ready",  64'((idx == 0) ? io0.in_ready  : io1.in_ready),  64'd1);
  endtask

  initial begin
    io0.product = '0; io0.tc = 1'b0; io0.dplx = 1'b0; io0.in_valid = 1'b0;
    io0.clr = 1'b0; io0.out_ready = 1'b0;
    io1.product = '0; io1.tc = 1'b0; io1.dplx = 1'b0; io1.in_valid = 1'b0;
    io1.clr = 1'b0; io1.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready",  64'(io0.in_ready),  64'd0);
    chk("rst_out_valid", 64'(io0.out_valid), 64'd0);
    chk("rst_acc",       64'(io0.acc_out),   64'd0);
    chk("rst_ovf",       64'(io0.ovf),       64'd0);
    chk("rst_out_valid1", 64'(io1.out_valid), 64'd0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_pre", 64'(io0.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(io0.in_ready), 64'd1);

    // Simplex unsigned
    pa = '{32'h10, 32'h10, 32'h10, 32'h10};
    send_frame(0, pa, 1'b0, 1'b0);
    chk("lit_simplex_acc", 64'(io0.acc_out), 64'h40);
    chk("lit_simplex_ovf", 64'(io0.ovf), 64'd0);
    handshake(0);

    // Duplex signed
    pa = '{32'hFFFF0002, 32'hFFFF0002, 32'hFFFF0002, 32'hFFFF0002};
    send_frame(0, pa, 1'b1, 1'b1);
    chk("lit_duplex_acc", 64'(io0.acc_out), 64'hFF_FFC0_0008);
    chk("lit_duplex_ovf", 64'(io0.ovf), 64'd0);
    handshake(0);

    // Back-pressure: result held, beats and clr ignored while pending
    pa = '{32'hFFFFFFF0, 32'h5, 32'h7, 32'hFFFFFFFE};
    send_frame(0, pa, 1'b1, 1'b0);
    io0.in_valid = 1'b1; io0.product = 32'h100; io0.tc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      io0.clr = (i == 1);
      @(posedge clk); #1;
      chk("hold_out_valid", 64'(io0.out_valid), 64'd1);
      chk("hold_in_ready",  64'(io0.in_ready),  64'd0);
      chk("hold_acc",       64'(io0.acc_out),   64'hFF_FFFF_FFFA);
    end
    io0.in_valid = 1'b0; io0.clr = 1'b0;
    handshake(0);

    // Duplex unsigned, mixed lanes
    pa = '{32'h1234_00FF, 32'hFFFF_FFFF, 32'h0001_8000, 32'h0000_0001};
    send_frame(0, pa, 1'b0, 1'b1);
    chk("lit_duplex_u_acc", 64'(io0.acc_out), 64'h11_2341_80FF);
    handshake(0);

    // Abort after two beats; the clr-cycle beat is dropped
    beat(0, 32'h5, 1'b0, 1'b0, 1'b0);
    beat(0, 32'h5, 1'b0, 1'b0, 1'b0);
    beat(0, 32'h7, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("clr_no_valid", 64'(io0.out_valid), 64'd0);
      @(posedge clk); #1;
    end
    pa = '{32'h1, 32'h1, 32'h1, 32'h1};
    send_frame(0, pa, 1'b0, 1'b0);
    chk("lit_after_clr", 64'(io0.acc_out), 64'h4);
    handshake(0);

    // guard=1 overflow, simplex unsigned
    pa = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    send_frame(1, pa, 1'b0, 1'b0);
    chk("lit_ovf_simplex", 64'(io1.ovf), 64'd1);
`ifdef DW_DX_ACCUM_SAT_EN
    chk("lit_ovf_simplex_acc", 64'(io1.acc_out), 64'h1_FFFF_FFFF);
`else
    chk("lit_ovf_simplex_acc", 64'(io1.acc_out), 64'h1_FFFF_FFFC);
`endif
    handshake(1);

    // guard=1 overflow, duplex signed, both lanes in opposite directions
    pa = '{32'h7FFF8000, 32'h7FFF8000, 32'h7FFF8000, 32'h7FFF8000};
    send_frame(1, pa, 1'b1, 1'b1);
    chk("lit_ovf_duplex", 64'(io1.ovf), 64'd3);
`ifdef DW_DX_ACCUM_SAT_EN
    chk("lit_ovf_duplex_acc", 64'(io1.acc_out), 64'h1_FFFF_0000);
`else
    chk("lit_ovf_duplex_acc", 64'(io1.acc_out), 64'h3_FFF8_0000);
`endif
    handshake(1);

    // Reset while a result is pending
    pa = '{32'h9, 32'h9, 32'h9, 32'h9};
    send_frame(0, pa, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_hold_out_valid", 64'(io0.out_valid), 64'd0);
    chk("rst_hold_acc",       64'(io0.acc_out),   64'd0);
    chk("rst_hold_ovf",       64'(io0.ovf),       64'd0);
    chk("rst_hold_in_ready",  64'(io0.in_ready),  64'd0);
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_in_ready", 64'(io0.in_ready), 64'd1);
    pa = '{32'h3, 32'h3, 32'h3, 32'h3};
    send_frame(0, pa, 1'b0, 1'b0);
    chk("lit_after_reset", 64'(io0.acc_out), 64'hC);
    handshake(0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
